// File: rtl/instr_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, reads the combinational instruction ROM,
// buffers {pc, instruction} pairs in a small circular queue for decode.
module instr_fetch_sequencer #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(QDEPTH);
  localparam logic [64:0]   MEM_LIMIT = 65'(MEM_BYTES);

  typedef enum logic {RUN, FAULT} state_t;

  state_t          state, state_nxt;
  logic [63:0]     pc;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [63:0]     q_pc    [QDEPTH];
  logic [31:0]     q_instr [QDEPTH];

  logic [64:0]     pc_end;
  logic            pc_legal;
  logic            pop;
  logic            push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The last byte of the word must lie inside the ROM; 65 bits so it cannot wrap.
  assign pc_end   = {1'b0, pc} + 65'd3;
  assign pc_legal = (pc[1:0] == 2'b00) && (pc_end < MEM_LIMIT);

  assign pop  = (count != '0) && out_ready;
  assign push = (state == RUN) && pc_legal && ((count < DEPTH_C) || pop);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (redirect_valid)
      state_nxt = RUN;
    else if ((state == RUN) && !pc_legal)
      state_nxt = FAULT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      fault_pc <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over any same-cycle push or pop.
      pc    <= redirect_target;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if ((state == RUN) && !pc_legal) fault_pc <= pc;
      if (push) begin
        pc   <= pc + 64'd4;
        tail <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; out_valid (count) alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (!redirect_valid && push) begin
      q_pc[tail]    <= pc;
      q_instr[tail] <= imem_instr;
    end
  end

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_pc    = q_pc[head];
  assign out_instr = q_instr[head];
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed vector table, an
// async-reset sequence, then randomized traffic against a queue-based model.
module tb_instr_fetch_sequencer;

  localparam int          MEM_BYTES = 1024;
  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam int          QDEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [63:0] fault_pc;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_sequencer #(
    .MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  // ROM word k holds value k.
  assign imem_instr = 32'(imem_addr >> 2);

  // Reference model: a plain queue of fetched entries plus pc / fault registers.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [63:0] m_pc;
  logic        m_fault;
  logic [63:0] m_fault_pc;

  task automatic model_reset();
    mq.delete();
    m_pc       = RESET_PC;
    m_fault    = 1'b0;
    m_fault_pc = '0;
  endtask

  task automatic model_step(input logic redir, input logic [63:0] tgt, input logic ready);
    logic legal;
    logic pop;
    legal = (m_pc[1:0] == 2'b00) && (({1'b0, m_pc} + 65'd3) < 65'(MEM_BYTES));
    pop   = (mq.size() > 0) && ready;
    if (redir) begin
      mq.delete();
      m_pc    = tgt;
      m_fault = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (!m_fault) begin
        if (!legal) begin
          m_fault    = 1'b1;
          m_fault_pc = m_pc;
        end else if (mq.size() < QDEPTH) begin
          mq.push_back('{pc: m_pc, instr: 32'(m_pc >> 2)});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      check({tag, " out_pc"},    out_pc,           mq[0].pc);
      check({tag, " out_instr"}, 64'(out_instr),   64'(mq[0].instr));
    end
    check({tag, " fault"},     64'(fault), 64'(m_fault));
    check({tag, " fault_pc"},  fault_pc,   m_fault_pc);
    check({tag, " imem_addr"}, imem_addr,  m_pc);
  endtask

  // Drive inputs (called right after a negedge), clock once, settle at the next negedge.
  task automatic step(input logic redir, input logic [63:0] tgt, input logic ready);
    redirect_valid  = redir;
    redirect_target = tgt;
    out_ready       = ready;
    @(posedge clk);
    model_step(redir, tgt, ready);
    @(negedge clk);
  endtask

  typedef struct {
    logic        redir;
    logic [63:0] tgt;
    logic        ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_addr;
    logic        e_fault;
    logic [63:0] e_fault_pc;
  } vec_t;

  vec_t vt[24];

  initial begin
    // stream from reset, no bubbles
    vt[0]  = '{0, 64'h0,   1, 1, 64'h0,   64'h4,   0, 64'h0};
    vt[1]  = '{0, 64'h0,   1, 1, 64'h4,   64'h8,   0, 64'h0};
    vt[2]  = '{0, 64'h0,   1, 1, 64'h8,   64'hC,   0, 64'h0};
    vt[3]  = '{0, 64'h0,   1, 1, 64'hC,   64'h10,  0, 64'h0};
    // five cycles of backpressure: one more push, then stall with pc held
    vt[4]  = '{0, 64'h0,   0, 1, 64'hC,   64'h14,  0, 64'h0};
    vt[5]  = '{0, 64'h0,   0, 1, 64'hC,   64'h14,  0, 64'h0};
    vt[6]  = '{0, 64'h0,   0, 1, 64'hC,   64'h14,  0, 64'h0};
    vt[7]  = '{0, 64'h0,   0, 1, 64'hC,   64'h14,  0, 64'h0};
    vt[8]  = '{0, 64'h0,   0, 1, 64'hC,   64'h14,  0, 64'h0};
    vt[9]  = '{0, 64'h0,   1, 1, 64'h10,  64'h18,  0, 64'h0};
    // queue holds 0x10, 0x14: redirect to 0x40 flushes it
    vt[10] = '{1, 64'h40,  1, 0, 64'h0,   64'h40,  0, 64'h0};
    vt[11] = '{0, 64'h0,   1, 1, 64'h40,  64'h44,  0, 64'h0};
    vt[12] = '{0, 64'h0,   1, 1, 64'h44,  64'h48,  0, 64'h0};
    // misaligned redirect faults one cycle later, aligned redirect recovers
    vt[13] = '{1, 64'h22,  1, 0, 64'h0,   64'h22,  0, 64'h0};
    vt[14] = '{0, 64'h0,   1, 0, 64'h0,   64'h22,  1, 64'h22};
    vt[15] = '{0, 64'h0,   1, 0, 64'h0,   64'h22,  1, 64'h22};
    vt[16] = '{1, 64'h20,  1, 0, 64'h0,   64'h20,  0, 64'h22};
    vt[17] = '{0, 64'h0,   1, 1, 64'h20,  64'h24,  0, 64'h22};
    // run off the end of the ROM, then drain
    vt[18] = '{1, 64'h3F8, 1, 0, 64'h0,   64'h3F8, 0, 64'h22};
    vt[19] = '{0, 64'h0,   0, 1, 64'h3F8, 64'h3FC, 0, 64'h22};
    vt[20] = '{0, 64'h0,   0, 1, 64'h3F8, 64'h400, 0, 64'h22};
    vt[21] = '{0, 64'h0,   0, 1, 64'h3F8, 64'h400, 1, 64'h400};
    vt[22] = '{0, 64'h0,   1, 1, 64'h3FC, 64'h400, 1, 64'h400};
    vt[23] = '{0, 64'h0,   1, 0, 64'h0,   64'h400, 1, 64'h400};

    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    out_ready       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset fault",     64'(fault),     64'd0);
    check("reset fault_pc",  fault_pc,       64'h0);
    check("reset imem_addr", imem_addr,      RESET_PC);

    for (int i = 0; i < 24; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vt[i].redir, vt[i].tgt, vt[i].ready);
      check({tag, " out_valid"}, 64'(out_valid), 64'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        check({tag, " out_pc"},    out_pc,         vt[i].e_pc);
        check({tag, " out_instr"}, 64'(out_instr), vt[i].e_pc >> 2);
      end
      check({tag, " imem_addr"}, imem_addr,   vt[i].e_addr);
      check({tag, " fault"},     64'(fault),  64'(vt[i].e_fault));
      check({tag, " fault_pc"},  fault_pc,    vt[i].e_fault_pc);
    end

    // Async reset between edges while faulted with a valid head entry.
    step(1'b1, 64'h3FC, 1'b0);
    step(1'b0, 64'h0,   1'b0);
    step(1'b0, 64'h0,   1'b0);
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    check("pre-reset fault",     64'(fault),     64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async out_valid", 64'(out_valid), 64'd0);
    check("async fault",     64'(fault),     64'd0);
    check("async fault_pc",  fault_pc,       64'h0);
    check("async imem_addr", imem_addr,      RESET_PC);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 64'h0, 1'b1);
    check("restart out_valid", 64'(out_valid), 64'd1);
    check("restart out_pc",    out_pc,         RESET_PC);
    step(1'b0, 64'h0, 1'b1);
    check("restart next pc",   out_pc,         RESET_PC + 64'd4);

    // Randomized traffic, including misaligned, end-of-ROM and far-out targets.
    for (int c = 0; c < 600; c++) begin
      logic        r;
      logic [63:0] t;
      logic        rdy;
      r   = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 4))
        0:       t = 64'({$urandom_range(0, 255), 2'b00});
        1:       t = 64'h3F0 + 64'({$urandom_range(0, 3), 2'b00});
        2:       t = 64'($urandom_range(0, 1023));
        3:       t = {$urandom, $urandom};
        default: t = 64'hFFFF_FFFF_FFFF_FFFC;
      endcase
      step(r, t, rdy);
      model_check($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Fetch-stage controller that owns the program counter and sequences the combinational instruction ROM. Each cycle it presents a word address, captures the returned instruction with its PC into a small fetch queue, and hands {pc, instruction} pairs to decode with a valid/ready handshake. Later pipeline stages redirect it on taken branches, and it enters a fault state, rather than issuing an illegal access, on misaligned or out-of-range PCs.

## Interface
- MEM_BYTES, 1024, instruction memory size in bytes; power of two, > 4
- RESET_PC, 64'h0, PC loaded on reset
- QDEPTH, 2, fetch queue entries; 2 or 4
- clk  in  1  single clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  64  byte address to instruction ROM; equals current PC
- imem_instr  in  32  ROM read data for imem_addr, same cycle
- redirect_valid  in  1  taken branch / jump from later stage
- redirect_target  in  64  new PC when redirect_valid
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  64  PC of head entry
- out_instr  out  32  instruction of head entry
- fault  out  1  sequencer stopped on illegal PC
- fault_pc  out  64  offending PC, latched on fault entry

## Operation
- States: RUN, FAULT. Reset enters RUN with pc=RESET_PC, queue empty, fault=0, fault_pc=0.
- A PC is legal iff pc[1:0]==0 and pc+3 < MEM_BYTES. Compute pc+3 at 64 bits with no wrap.
- Pop: out_valid && out_ready. Push-eligible: state==RUN, PC legal, and count<QDEPTH or a pop happens in the same cycle.
- RUN, no redirect:
  - If push-eligible, enqueue {pc, imem_instr} and advance pc by 4.
  - If the PC is illegal, go to FAULT, set fault=1 and fault_pc=pc, and do not enqueue. pc holds.
  - If the queue is full with no pop, pc holds and nothing is enqueued (stall).
- Redirect has highest priority in either state:
  - Flush the queue (count=0) and discard any same-cycle pop or push.
  - Load pc=redirect_target.
  - Go to RUN and clear fault. fault_pc keeps its last value.
  - Target legality is checked on the following cycle like any other PC.
- FAULT: no fetching, and pc holds. Existing queue entries still drain to decode normally. Only redirect or reset leaves FAULT.
- Queue is a circular buffer with head/tail pointers wrapping modulo QDEPTH. Simultaneous push and pop keeps count constant and is legal at full or empty.
- The block never depends on imem_instr when the PC is illegal, and never enqueues X data from an illegal access.

## Timing
- imem_addr is the pc register output (no combinational path from inputs).
- out_valid, out_pc and out_instr are registered queue-head outputs with no combinational path from out_ready or redirect.
- Latency: PC presented in cycle N appears at the queue head in cycle N+1 when the queue was empty.
- Sustained throughput is 1 instruction/cycle with out_ready held high, at any QDEPTH.
- After a redirect at edge N, the target's instruction is valid at the output in cycle N+2. out_valid=0 in cycle N+1.
- Reset mid-operation asynchronously clears queue, state, fault and fault_pc. out_valid goes 0 immediately.
- Entering FAULT is visible on the fault output in the cycle after the illegal PC was presented.

## Test plan
- Reset and stream: ROM word k = k. Hold out_ready=1 after reset release. Expect out_valid in the first cycle after the first edge, then out_pc=0,4,8,… and out_instr=0,1,2,… on consecutive cycles with no bubbles.
- Backpressure: out_ready=0 for 5 cycles after 2 pushes (QDEPTH=2). Expect pc held at 8, head stays pc=0, then in-order resume with no loss or duplicate.
- Redirect: redirect_target=0x40 while the queue holds pc 0x10 and 0x14, with out_ready=1. Expect flush, out_valid=0 for 1 cycle, then out_pc=0x40, 0x44.
- Run off the end: MEM_BYTES=1024, RESET_PC=0x3F8. Expect pcs 0x3F8 and 0x3FC delivered, then fault=1 with fault_pc=0x400, no further pushes, and the queue drains.
- Misaligned redirect: target 0x22. Expect fault=1 and fault_pc=0x22 next cycle. A following redirect to 0x20 clears fault and delivers pc 0x20.
- Async reset mid-stream: assert reset_n low between edges. Expect out_valid=0 and fault=0 immediately, and restart from RESET_PC after release.
